cpu_eu_param: RTL and testbench
===============================

# cpu_eu_param

Parametrised execution unit for the 16-bit RISC CPU family. It combines a register file, an ALU, a registered flag set, a program counter, an instruction register, an address multiplexer and a hardware return-address stack. The external control unit (FSM) drives it one operation per clock. New behaviour in this generation:
- parametrised width and register count;
- registered flags with an explicit enable;
- conditional relative branch;
- CALL/RET with full/empty detection and a sticky error flag.

## Interface
Parameters:
- DW, 16, data, address and PC width
- RA, 3, register address bits (2^RA registers)
- OFS_W, 8, branch offset width, taken from IR[OFS_W-1:0]
- STK_D, 4, return stack depth (must be ≥1)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- w_en  in  1  register file write enable
- w_adr, r_adr, s_adr  in  RA  write, R-operand and S-operand addresses
- s_sel  in  1  S operand source: 1 = d_in, 0 = reg[s_adr]
- alu_op  in  4  ALU operation
- flag_en  in  1  latch ALU flags into c/n/z
- pc_op  in  3  PC operation
- cc  in  2  branch condition: 0 = always, 1 = z, 2 = c, 3 = n
- ir_en  in  1  load IR from d_in
- adr_sel  in  1  address source: 1 = reg[r_adr], 0 = PC
- d_in  in  DW  memory read data
- d_out  out  DW  ALU result (combinational)
- address  out  DW  memory address (combinational)
- ir_out  out  DW  instruction register
- c, n, z  out  1  registered flags
- stk_full, stk_empty  out  1  return stack status
- err  out  1  sticky stack overflow/underflow

## Operation
- **Register file:**
  - 2^RA x DW registers.
  - Write of d_out into reg[w_adr] at the clock edge when w_en=1.
  - Reads are combinational with no write bypass: a same-cycle read returns the old value.
- **ALU:** R = reg[r_adr]; S = s_sel ? d_in : reg[s_adr]. All arithmetic is modulo 2^DW.
  - 0: R
  - 1: S
  - 2: R+1
  - 3: R-1
  - 4: R+S
  - 5: R-S
  - 6: S>>1 (logical)
  - 7: S<<1
  - 8: R&S
  - 9: R|S
  - 10: R^S
  - 11: ~S
  - 12: -S
  - 13: R+S+c
  - 14: 0
  - 15: S>>>1 (arithmetic)
- **Flags:**
  - Flag definitions:
    - n = d_out[DW-1].
    - z = (d_out==0).
    - c = carry-out for ops 2, 4 and 13.
    - c = borrow for ops 3, 5 and 12.
    - c = shifted-out bit for ops 6, 7 and 15.
    - c = 0 otherwise.
  - The flags are latched only when flag_en=1.
- **PC operations (pc_op):**
  - 0 HOLD
  - 1 INC: PC+1
  - 2 REL: PC + sext(IR[OFS_W-1:0])
  - 3 ABS: PC <= d_out
  - 4 CALL: push PC+1, then PC <= d_out
  - 5 RET: PC <= pop
  - 6 BRC: REL if the condition selected by cc (using the registered flags) is true, else INC
  - 7 reserved: behaves as HOLD
- **Return stack:**
  - LIFO of STK_D entries.
  - stk_full = (count==STK_D); stk_empty = (count==0).
  - **CALL when full:**
    - The push is suppressed.
    - PC still loads d_out.
    - err is set.
  - **RET when empty:**
    - PC is held.
    - err is set.
  - err clears only on reset.
- **IR:** loads d_in when ir_en=1. REL and BRC in the same cycle use the old IR value.
- **Address:** address = adr_sel ? reg[r_adr] : PC.

## Timing
- **Reset (reset=0):**
  - Asynchronous and immediate.
  - PC, IR, all registers, c, n, z, stack count and err are cleared to 0.
  - stk_empty=1, stk_full=0.
  - Outputs settle combinationally from the cleared state.
- **Clocked updates:** all state updates on the rising edge of clk, single cycle. d_out and address are valid in the same cycle their inputs change.
- **Simultaneous events:** w_en, flag_en, ir_en and pc_op may all be active in the same cycle.
  - Each operation uses pre-edge values.
  - Example: BRC evaluates the old flags even when flag_en=1 in that cycle.
  - Example: ABS and CALL use d_out computed from pre-edge register contents.
- **Wrap-around:**
  - PC wraps modulo 2^DW on INC, REL and CALL+1.
  - The stack pointer never wraps.
- **Reset mid-operation:** reset asserted between edges aborts any pending update. No partial state survives.

## Test plan
- **Reset:** release reset → PC=0, address=0, c/n/z=0, stk_empty=1, err=0.
- **ALU and flags:** load reg1=0xFFFF via d_in (s_sel=1, op 1, w_en); then op 2 on reg1 with flag_en → d_out=0x0000, c=1, z=1, n=0. Repeat with flag_en=0 → flags unchanged.
- **Conditional branch:** IR=0x00FE, PC=0x0010, z=1.
  - BRC cc=1 → PC=0x000E.
  - With z=0 → PC=0x0011.
  - With PC=0xFFFF and INC → PC=0x0000.
- **Call/return:**
  - Four CALLs to 0x0100, 0x0200, 0x0300, 0x0400 from PC=0x0005, each executed from the prior target → stk_full=1, err=0.
  - Fifth CALL → PC=d_out, err=1, stack unchanged.
  - Four RETs → PC = 0x0301, 0x0201, 0x0101, 0x0006.
  - Fifth RET → PC held.
- **Same-cycle interaction:** ir_en with d_in=0x0003 and REL in the same cycle, old IR=0x0001, PC=0x0020 → PC=0x0021, IR=0x0003. A write plus read of the same register returns the old value in that cycle.
- **Mid-operation reset:** assert reset between edges during a CALL → stack empty, err=0, PC=0 immediately.

Source files
------------

// File: rtl/cpu_eu_param_if.sv
// Control/data bundle between the CPU control unit and the execution unit.
// The master (control unit) drives operation selects and memory read data.
`timescale 1ns/1ps
interface cpu_eu_param_if #(
    parameter int DW = 16,
    parameter int RA = 3
);
    logic          w_en;
    logic [RA-1:0] w_adr;
    logic [RA-1:0] r_adr;
    logic [RA-1:0] s_adr;
    logic          s_sel;
    logic [3:0]    alu_op;
    logic          flag_en;
    logic [2:0]    pc_op;
    logic [1:0]    cc;
    logic          ir_en;
    logic          adr_sel;
    logic [DW-1:0] d_in;

    logic [DW-1:0] d_out;
    logic [DW-1:0] address;
    logic [DW-1:0] ir_out;
    logic          c;
    logic          n;
    logic          z;
    logic          stk_full;
    logic          stk_empty;
    logic          err;

    modport master (
        output w_en, w_adr, r_adr, s_adr, s_sel, alu_op, flag_en,
               pc_op, cc, ir_en, adr_sel, d_in,
        input  d_out, address, ir_out, c, n, z, stk_full, stk_empty, err
    );

    modport slave (
        input  w_en, w_adr, r_adr, s_adr, s_sel, alu_op, flag_en,
               pc_op, cc, ir_en, adr_sel, d_in,
        output d_out, address, ir_out, c, n, z, stk_full, stk_empty, err
    );
endinterface

// File: rtl/cpu_eu_param.sv
// Execution unit: register file, ALU with registered flags, PC with
// conditional branch, instruction register and a hardware return stack.
`timescale 1ns/1ps
module cpu_eu_param #(
    parameter int DW    = 16,
    parameter int RA    = 3,
    parameter int OFS_W = 8,
    parameter int STK_D = 4
) (
    input  logic           clk,
    input  logic           reset,
    cpu_eu_param_if.slave  bus
);
    localparam int NREG = 1 << RA;
    localparam int CW   = $clog2(STK_D + 1);
    localparam logic [DW:0] ONE_X  = {{DW{1'b0}}, 1'b1};
    localparam logic [DW:0] ZERO_X = '0;

    typedef enum logic [2:0] {
        PC_HOLD = 3'd0,
        PC_INC  = 3'd1,
        PC_REL  = 3'd2,
        PC_ABS  = 3'd3,
        PC_CALL = 3'd4,
        PC_RET  = 3'd5,
        PC_BRC  = 3'd6,
        PC_RSVD = 3'd7
    } pc_op_t;

    pc_op_t        pc_op;
    logic [DW-1:0] regs_rd [NREG];
    logic [DW-1:0] stk_q   [STK_D];
    logic [DW-1:0] r_val;
    logic [DW-1:0] s_val;
    logic [DW-1:0] alu_res;
    logic          alu_c;
    logic [DW:0]   ext;
    logic          use_ext;

    logic [DW-1:0] pc_reg, pc_next;
    logic [DW-1:0] ir_reg;
    logic          c_reg, n_reg, z_reg;
    logic [CW-1:0] sp_reg, sp_next;
    logic          err_reg, err_next;
    logic          push;
    logic [DW-1:0] stk_rd;
    logic          stk_full;
    logic          stk_empty;
    logic [DW-1:0] pc_inc;
    logic [DW-1:0] pc_rel;
    logic [DW-1:0] ofs_sext;
    logic          cond_true;

    assign pc_op = pc_op_t'(bus.pc_op);

    // Register file: one flop bank per entry, reads are unbypassed.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_rf
            logic [DW-1:0] q_reg;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)
                    q_reg <= '0;
                else if (bus.w_en && (bus.w_adr == RA'(gi)))
                    q_reg <= alu_res;
            end
            assign regs_rd[gi] = q_reg;
        end
    endgenerate

    assign r_val = regs_rd[bus.r_adr];
    assign s_val = bus.s_sel ? bus.d_in : regs_rd[bus.s_adr];

    // Arithmetic ops go through a DW+1 wide result whose top bit is carry/borrow.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        ext     = '0;
        use_ext = 1'b0;
        case (bus.alu_op)
            4'd0:  alu_res = r_val;
            4'd1:  alu_res = s_val;
            4'd2:  begin ext = {1'b0, r_val} + ONE_X;          use_ext = 1'b1; end
            4'd3:  begin ext = {1'b0, r_val} - ONE_X;          use_ext = 1'b1; end
            4'd4:  begin ext = {1'b0, r_val} + {1'b0, s_val};  use_ext = 1'b1; end
            4'd5:  begin ext = {1'b0, r_val} - {1'b0, s_val};  use_ext = 1'b1; end
            4'd6:  begin alu_res = {1'b0, s_val[DW-1:1]}; alu_c = s_val[0]; end
            4'd7:  begin alu_res = {s_val[DW-2:0], 1'b0}; alu_c = s_val[DW-1]; end
            4'd8:  alu_res = r_val & s_val;
            4'd9:  alu_res = r_val | s_val;
            4'd10: alu_res = r_val ^ s_val;
            4'd11: alu_res = ~s_val;
            4'd12: begin ext = ZERO_X - {1'b0, s_val};         use_ext = 1'b1; end
            4'd13: begin
                ext     = {1'b0, r_val} + {1'b0, s_val} + {{DW{1'b0}}, c_reg};
                use_ext = 1'b1;
            end
            4'd14: alu_res = '0;
            default: begin alu_res = {s_val[DW-1], s_val[DW-1:1]}; alu_c = s_val[0]; end
        endcase
        if (use_ext) begin
            alu_res = ext[DW-1:0];
            alu_c   = ext[DW];
        end
    end

    assign ofs_sext = {{(DW - OFS_W){ir_reg[OFS_W-1]}}, ir_reg[OFS_W-1:0]};
    assign pc_inc   = pc_reg + {{(DW-1){1'b0}}, 1'b1};
    assign pc_rel   = pc_reg + ofs_sext;

    always_comb begin
        case (bus.cc)
            2'd0:    cond_true = 1'b1;
            2'd1:    cond_true = z_reg;
            2'd2:    cond_true = c_reg;
            default: cond_true = n_reg;
        endcase
    end

    assign stk_full  = (sp_reg == CW'(STK_D));
    assign stk_empty = (sp_reg == '0);

    // Top of stack lives at entry sp-1.
    always_comb begin
        stk_rd = '0;
        for (int i = 0; i < STK_D; i++) begin
            if (sp_reg == CW'(i + 1))
                stk_rd = stk_q[i];
        end
    end

    // Next PC / stack state; overflow and underflow only raise the sticky error.
    always_comb begin
        pc_next  = pc_reg;
        sp_next  = sp_reg;
        err_next = err_reg;
        push     = 1'b0;
        case (pc_op)
            PC_INC:  pc_next = pc_inc;
            PC_REL:  pc_next = pc_rel;
            PC_ABS:  pc_next = alu_res;
            PC_CALL: begin
                pc_next = alu_res;
                if (stk_full) begin
                    err_next = 1'b1;
                end else begin
                    push    = 1'b1;
                    sp_next = sp_reg + CW'(1);
                end
            end
            PC_RET: begin
                if (stk_empty) begin
                    err_next = 1'b1;
                end else begin
                    pc_next = stk_rd;
                    sp_next = sp_reg - CW'(1);
                end
            end
            PC_BRC:  pc_next = cond_true ? pc_rel : pc_inc;
            PC_HOLD, PC_RSVD: pc_next = pc_reg;
            default: pc_next = pc_reg;
        endcase
    end

    generate
        for (gi = 0; gi < STK_D; gi++) begin : g_stk
            logic [DW-1:0] e_reg;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)
                    e_reg <= '0;
                else if (push && (sp_reg == CW'(gi)))
                    e_reg <= pc_inc;
            end
            assign stk_q[gi] = e_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_reg  <= '0;
            ir_reg  <= '0;
            c_reg   <= 1'b0;
            n_reg   <= 1'b0;
            z_reg   <= 1'b0;
            sp_reg  <= '0;
            err_reg <= 1'b0;
        end else begin
            pc_reg  <= pc_next;
            sp_reg  <= sp_next;
            err_reg <= err_next;
            if (bus.ir_en)
                ir_reg <= bus.d_in;
            if (bus.flag_en) begin
                c_reg <= alu_c;
                n_reg <= alu_res[DW-1];
                z_reg <= (alu_res == '0);
            end
        end
    end

    assign bus.d_out     = alu_res;
    assign bus.address   = bus.adr_sel ? r_val : pc_reg;
    assign bus.ir_out    = ir_reg;
    assign bus.c         = c_reg;
    assign bus.n         = n_reg;
    assign bus.z         = z_reg;
    assign bus.stk_full  = stk_full;
    assign bus.stk_empty = stk_empty;
    assign bus.err       = err_reg;
endmodule

// File: tb/tb_cpu_eu_param.sv
// Directed bench for cpu_eu_param: ALU vector table plus hand-written
// branch, call/return, same-cycle and mid-operation reset sequences.
`timescale 1ns/1ps
module tb_cpu_eu_param;
    localparam int DW = 16;
    localparam int RA = 3;
    localparam int NV = 21;

    typedef struct {
        logic [2:0]  r;
        logic        ss;
        logic [2:0]  sa;
        logic [3:0]  op;
        logic [15:0] din;
        logic [15:0] dout;
        logic [2:0]  cnz;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   passed = 0;
    vec_t vecs [NV];
    logic [15:0] ret_exp [4];

    always #5 clk = ~clk;

    cpu_eu_param_if #(.DW(DW), .RA(RA)) bus ();

    cpu_eu_param #(.DW(DW), .RA(RA), .OFS_W(8), .STK_D(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.w_en = 1'b0;  bus.w_adr = '0; bus.r_adr = '0; bus.s_adr = '0;
        bus.s_sel = 1'b0; bus.alu_op = 4'd0; bus.flag_en = 1'b0;
        bus.pc_op = 3'd0; bus.cc = 2'd0; bus.ir_en = 1'b0;
        bus.adr_sel = 1'b0; bus.d_in = '0;
    endtask

    task automatic load_reg(input logic [2:0] a, input logic [15:0] v);
        idle(); bus.s_sel = 1'b1; bus.alu_op = 4'd1; bus.d_in = v;
        bus.w_en = 1'b1; bus.w_adr = a;
        tick();
    endtask

    task automatic set_pc(input logic [15:0] v, input logic fe);
        idle(); bus.s_sel = 1'b1; bus.alu_op = 4'd1; bus.d_in = v;
        bus.pc_op = 3'd3; bus.flag_en = fe;
        tick();
    endtask

    task automatic set_ir(input logic [15:0] v);
        idle(); bus.ir_en = 1'b1; bus.d_in = v;
        tick();
    endtask

    task automatic chk_pc(input string name, input logic [15:0] exp);
        bus.adr_sel = 1'b0;
        #1;
        chk(name, bus.address, exp);
        $display("%s: pc=%h", name, bus.address);
    endtask

    task automatic do_call(input logic [15:0] tgt);
        idle(); bus.s_sel = 1'b1; bus.alu_op = 4'd1; bus.d_in = tgt; bus.pc_op = 3'd4;
        tick();
    endtask

    function automatic logic [15:0] flags3();
        return {13'd0, bus.c, bus.n, bus.z};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        //         r     ss    sa    op     din        dout       cnz
        vecs[0]  = '{3'd1, 1'b1, 3'd0, 4'd0,  16'h0000, 16'h8001, 3'b010};
        vecs[1]  = '{3'd1, 1'b1, 3'd0, 4'd1,  16'h0000, 16'h0000, 3'b001};
        vecs[2]  = '{3'd3, 1'b1, 3'd0, 4'd2,  16'h0000, 16'h0000, 3'b101};
        vecs[3]  = '{3'd2, 1'b1, 3'd0, 4'd3,  16'h0000, 16'hFFFF, 3'b110};
        vecs[4]  = '{3'd1, 1'b1, 3'd0, 4'd4,  16'h8000, 16'h0001, 3'b100};
        vecs[5]  = '{3'd1, 1'b1, 3'd0, 4'd5,  16'h0002, 16'h7FFF, 3'b000};
        vecs[6]  = '{3'd2, 1'b1, 3'd0, 4'd5,  16'h0001, 16'hFFFF, 3'b110};
        vecs[7]  = '{3'd0, 1'b1, 3'd0, 4'd6,  16'h8003, 16'h4001, 3'b100};
        vecs[8]  = '{3'd0, 1'b1, 3'd0, 4'd7,  16'h8003, 16'h0006, 3'b100};
        vecs[9]  = '{3'd1, 1'b1, 3'd0, 4'd8,  16'h00FF, 16'h0001, 3'b000};
        vecs[10] = '{3'd1, 1'b1, 3'd0, 4'd9,  16'h0F00, 16'h8F01, 3'b010};
        vecs[11] = '{3'd1, 1'b1, 3'd0, 4'd10, 16'h8001, 16'h0000, 3'b001};
        vecs[12] = '{3'd0, 1'b1, 3'd0, 4'd11, 16'h00FF, 16'hFF00, 3'b010};
        vecs[13] = '{3'd0, 1'b1, 3'd0, 4'd12, 16'h0001, 16'hFFFF, 3'b110};
        vecs[14] = '{3'd0, 1'b1, 3'd0, 4'd12, 16'h0000, 16'h0000, 3'b001};
        vecs[15] = '{3'd3, 1'b1, 3'd0, 4'd2,  16'h0000, 16'h0000, 3'b101};
        vecs[16] = '{3'd1, 1'b1, 3'd0, 4'd13, 16'h7FFE, 16'h0000, 3'b101};
        vecs[17] = '{3'd2, 1'b1, 3'd0, 4'd13, 16'h0005, 16'h0006, 3'b000};
        vecs[18] = '{3'd1, 1'b1, 3'd0, 4'd14, 16'h1234, 16'h0000, 3'b001};
        vecs[19] = '{3'd0, 1'b1, 3'd0, 4'd15, 16'h8003, 16'hC001, 3'b110};
        vecs[20] = '{3'd1, 1'b0, 3'd3, 4'd4,  16'h0000, 16'h8000, 3'b110};
        ret_exp[0] = 16'h0301; ret_exp[1] = 16'h0201;
        ret_exp[2] = 16'h0101; ret_exp[3] = 16'h0006;

        idle();
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk_pc("reset pc", 16'h0000);
        chk("reset flags", flags3(), 16'h0000);
        chk("reset stk_empty", {15'd0, bus.stk_empty}, 16'h0001);
        chk("reset stk_full", {15'd0, bus.stk_full}, 16'h0000);
        chk("reset err", {15'd0, bus.err}, 16'h0000);
        chk("reset ir", bus.ir_out, 16'h0000);

        // ALU table
        load_reg(3'd1, 16'h8001);
        load_reg(3'd3, 16'hFFFF);
        for (int i = 0; i < NV; i++) begin
            idle();
            bus.r_adr = vecs[i].r; bus.s_sel = vecs[i].ss; bus.s_adr = vecs[i].sa;
            bus.alu_op = vecs[i].op; bus.d_in = vecs[i].din; bus.flag_en = 1'b1;
            #1;
            chk($sformatf("vec%0d d_out", i), bus.d_out, vecs[i].dout);
            tick();
            chk($sformatf("vec%0d flags", i), flags3(), {13'd0, vecs[i].cnz});
            $display("vec %0d op=%0d d_out=%h cnz=%b", i, vecs[i].op, vecs[i].dout, vecs[i].cnz);
        end

        // INC of 0xFFFF with flags, then flag_en=0 keeps them
        load_reg(3'd4, 16'hFFFF);
        idle(); bus.r_adr = 3'd4; bus.alu_op = 4'd2; bus.flag_en = 1'b1;
        #1 chk("inc ffff d_out", bus.d_out, 16'h0000);
        tick();
        chk("inc ffff flags", flags3(), 16'h0005);
        idle(); bus.r_adr = 3'd4; bus.alu_op = 4'd0;
        tick();
        chk("flag_en=0 hold", flags3(), 16'h0005);

        // Conditional branch
        set_ir(16'h00FE);
        set_pc(16'h0010, 1'b0);
        idle(); bus.alu_op = 4'd14; bus.flag_en = 1'b1; tick();
        idle(); bus.pc_op = 3'd6; bus.cc = 2'd1; tick();
        chk_pc("brc z=1 taken", 16'h000E);
        set_pc(16'h0010, 1'b1);
        idle(); bus.pc_op = 3'd6; bus.cc = 2'd1; tick();
        chk_pc("brc z=0 not taken", 16'h0011);
        idle(); bus.pc_op = 3'd6; bus.cc = 2'd0; tick();
        chk_pc("brc always", 16'h000F);
        idle(); bus.pc_op = 3'd6; bus.cc = 2'd2; tick();
        chk_pc("brc c=0", 16'h0010);
        idle(); bus.pc_op = 3'd7; tick();
        chk_pc("pc_op 7 hold", 16'h0010);
        idle(); bus.alu_op = 4'd14; bus.flag_en = 1'b1; tick();
        idle(); bus.pc_op = 3'd6; bus.cc = 2'd1;
        bus.s_sel = 1'b1; bus.alu_op = 4'd1; bus.d_in = 16'h0005; bus.flag_en = 1'b1;
        tick();
        chk_pc("brc old flags", 16'h000E);
        chk("brc new z", flags3(), 16'h0000);
        set_pc(16'hFFFF, 1'b0);
        idle(); bus.pc_op = 3'd1; tick();
        chk_pc("inc wrap", 16'h0000);

        // Call / return
        set_pc(16'h0005, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            do_call(16'(k << 8));
            chk_pc($sformatf("call%0d", k), 16'(k << 8));
        end
        chk("four calls full", {15'd0, bus.stk_full}, 16'h0001);
        chk("four calls err", {15'd0, bus.err}, 16'h0000);
        do_call(16'h0500);
        chk_pc("call5 pc", 16'h0500);
        chk("call5 err", {15'd0, bus.err}, 16'h0001);
        chk("call5 full", {15'd0, bus.stk_full}, 16'h0001);
        for (int k = 0; k < 4; k++) begin
            idle(); bus.pc_op = 3'd5; tick();
            chk_pc($sformatf("ret%0d", k + 1), ret_exp[k]);
        end
        chk("rets empty", {15'd0, bus.stk_empty}, 16'h0001);
        idle(); bus.pc_op = 3'd5; tick();
        chk_pc("ret5 held", 16'h0006);
        chk("ret5 err", {15'd0, bus.err}, 16'h0001);

        // IR load with REL in the same cycle
        set_ir(16'h0001);
        set_pc(16'h0020, 1'b0);
        idle(); bus.ir_en = 1'b1; bus.d_in = 16'h0003; bus.pc_op = 3'd2; tick();
        chk_pc("rel old ir", 16'h0021);
        chk("ir new", bus.ir_out, 16'h0003);

        // Write and read of the same register
        load_reg(3'd5, 16'h0010);
        idle(); bus.r_adr = 3'd5; bus.w_adr = 3'd5; bus.w_en = 1'b1;
        bus.alu_op = 4'd2; bus.adr_sel = 1'b1;
        #1;
        chk("wr/rd old value", bus.address, 16'h0010);
        chk("wr/rd d_out", bus.d_out, 16'h0011);
        tick();
        chk("wr/rd after edge", bus.address, 16'h0011);

        // Reset between edges during a CALL
        do_call(16'h0700);
        chk("pre-reset stack", {15'd0, bus.stk_empty}, 16'h0000);
        idle(); bus.s_sel = 1'b1; bus.alu_op = 4'd1; bus.d_in = 16'h0800; bus.pc_op = 3'd4;
        #2 reset = 1'b0;
        #1;
        chk("midrst pc", bus.address, 16'h0000);
        chk("midrst empty", {15'd0, bus.stk_empty}, 16'h0001);
        chk("midrst err", {15'd0, bus.err}, 16'h0000);
        chk("midrst ir", bus.ir_out, 16'h0000);
        chk("midrst flags", flags3(), 16'h0000);
        bus.adr_sel = 1'b1; bus.r_adr = 3'd1;
        #1 chk("midrst reg1", bus.address, 16'h0000);
        bus.adr_sel = 1'b0;
        tick();
        chk_pc("reset held pc", 16'h0000);
        idle();
        reset = 1'b1;
        tick();
        chk_pc("post-reset pc", 16'h0000);
        chk("post-reset empty", {15'd0, bus.stk_empty}, 16'h0001);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
